// File: rtl/aes_job_arbiter_if.sv
// aes_job_arbiter_if: job inputs, controller stream/result paths and status of aes_job_arbiter
interface aes_job_arbiter_if #(
  parameter int DATA_W = 128,
  parameter int CMD_W  = 32,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] s0_tdata, s1_tdata, m_tdata, r_tdata, o0_tdata, o1_tdata;
  logic s0_tvalid, s0_tready, s0_tlast, s1_tvalid, s1_tready, s1_tlast;
  logic [CMD_W-1:0] s0_cmd, s1_cmd, m_cmd;
  logic m_tvalid, m_tready, m_tlast;
  logic r_tvalid, r_tready, done_i;
  logic o0_tvalid, o0_tready, o1_tvalid, o1_tready;
  logic [CNT_W-1:0] jobs_done0, jobs_done1;
  logic owner, busy, timeout_err;
  modport slave (
    input  s0_tdata, s0_tvalid, s0_tlast, s0_cmd, s1_tdata, s1_tvalid, s1_tlast, s1_cmd,
    input  m_tready, r_tdata, r_tvalid, done_i, o0_tready, o1_tready,
    output s0_tready, s1_tready, m_tdata, m_tvalid, m_tlast, m_cmd, r_tready,
    output o0_tdata, o0_tvalid, o1_tdata, o1_tvalid, jobs_done0, jobs_done1, owner, busy, timeout_err
  );
  modport master (
    output s0_tdata, s0_tvalid, s0_tlast, s0_cmd, s1_tdata, s1_tvalid, s1_tlast, s1_cmd,
    output m_tready, r_tdata, r_tvalid, done_i, o0_tready, o1_tready,
    input  s0_tready, s1_tready, m_tdata, m_tvalid, m_tlast, m_cmd, r_tready,
    input  o0_tdata, o0_tvalid, o1_tdata, o1_tvalid, jobs_done0, jobs_done1, owner, busy, timeout_err
  );
endinterface

// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: round-robin whole-job arbiter sharing one AES controller; AES_ARB_TIMEOUT_EN adds a DRAIN watchdog
module aes_job_arbiter #(
  parameter int DATA_W      = 128,
  parameter int CMD_W       = 32,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic clk,
  input logic reset,
  aes_job_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, FWD = 2'd1, DRAIN = 2'd2;
  logic [1:0] state;
  logic owner, rr_ptr, done_q, done_seen;
  logic [CMD_W-1:0] cmd;
  logic [CNT_W-1:0] jobs0, jobs1;
  logic fwd, act, grant, done_rise, last_hs, done_exit, expire;
  always_comb begin
    fwd = state == FWD;
    act = state != IDLE;
    grant = (rr_ptr ? bus.s1_tvalid : bus.s0_tvalid) ? rr_ptr : ~rr_ptr;
    done_rise = bus.done_i & ~done_q;
    last_hs = bus.m_tvalid & bus.m_tready & bus.m_tlast;
    done_exit = state == DRAIN && (done_rise || done_seen);
  end
  assign bus.m_tdata = owner ? bus.s1_tdata : bus.s0_tdata;
  assign bus.m_tlast = fwd & (owner ? bus.s1_tlast : bus.s0_tlast);
  assign bus.m_tvalid = fwd & (owner ? bus.s1_tvalid : bus.s0_tvalid);
  assign bus.s0_tready = fwd & ~owner & bus.m_tready;
  assign bus.s1_tready = fwd & owner & bus.m_tready;
  assign bus.m_cmd = cmd;
  assign bus.r_tready = act & (owner ? bus.o1_tready : bus.o0_tready);
  assign bus.o0_tdata = bus.r_tdata;
  assign bus.o1_tdata = bus.r_tdata;
  assign bus.o0_tvalid = act & ~owner & bus.r_tvalid;
  assign bus.o1_tvalid = act & owner & bus.r_tvalid;
  assign bus.jobs_done0 = jobs0;
  assign bus.jobs_done1 = jobs1;
  assign bus.owner = owner;
  assign bus.busy = act;
`ifdef AES_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] tmo;
  logic terr;
  assign expire = state == DRAIN && tmo == TO_W'(TIMEOUT_CYC - 1);
  assign bus.timeout_err = terr;
  // Counter sits at zero outside DRAIN, so it is already cleared on entry.
  always_ff @(posedge clk) begin
    tmo <= (reset || state != DRAIN) ? '0 : tmo + 1'b1;
    terr <= !reset && expire && !done_exit;
  end
`else
  logic unused_to;
  assign unused_to = ^TIMEOUT_CYC;
  assign expire = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      rr_ptr <= 1'b0;
      cmd <= '0;
      jobs0 <= '0;
      jobs1 <= '0;
      done_q <= 1'b0;
      done_seen <= 1'b0;
    end else begin
      done_q <= bus.done_i;
      if (state == IDLE && (bus.s0_tvalid || bus.s1_tvalid)) begin
        state <= FWD;
        owner <= grant;
        cmd <= grant ? bus.s1_cmd : bus.s0_cmd;
        done_seen <= 1'b0;
      end
      if (fwd) begin
        if (done_rise) done_seen <= 1'b1;
        if (last_hs) state <= DRAIN;
      end
      if (done_exit) begin
        state <= IDLE;
        rr_ptr <= ~owner;
        if (owner) jobs1 <= jobs1 + 1'b1;
        else jobs0 <= jobs0 + 1'b1;
      end else if (expire) begin
        state <= IDLE;
        rr_ptr <= ~owner;
      end
    end
  end
endmodule
